// File: rtl/vfd_grid_capture.sv
// Captures debounced VFD grid/plate drive into a row buffer with per-row phosphor decay.
// Row update STABLE+1 clocks after the last input change, read port adds one clock; no backpressure.
module vfd_grid_capture #(
   parameter int GRIDS  = 16,
   parameter int PLATES = 24,
   parameter int STABLE = 8,
   parameter int DECAY  = 40000,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [GRIDS-1:0]  grid,
   input  logic [PLATES-1:0] plate,
   input  logic [AW-1:0]     rd_addr,
   output logic [PLATES-1:0] rd_data,
   output logic [GRIDS-1:0]  row_lit,
   output logic              changed
);

   localparam int SW = $clog2(STABLE + 1);
   localparam int DW = $clog2(DECAY + 1);

   logic [GRIDS-1:0]  grid_q;
   logic [PLATES-1:0] plate_q;
   logic [SW-1:0]     stab_cnt_q, stab_cnt_d;
   logic              stable;

   logic [PLATES-1:0] row_q  [GRIDS];
   logic [PLATES-1:0] row_d  [GRIDS];
   logic [DW-1:0]     dcnt_q [GRIDS];
   logic [DW-1:0]     dcnt_d [GRIDS];
   logic [GRIDS-1:0]  lit_q, lit_d;
   logic              changed_q, changed_d;
   logic [PLATES-1:0] rd_data_q, rd_data_d;

   // Stability is judged on the count being loaded this edge, so the write lands STABLE+1 clocks after a change.
   always_comb begin
      stab_cnt_d = stab_cnt_q;
      if ({grid, plate} != {grid_q, plate_q}) begin
         stab_cnt_d = '0;
      end else if (stab_cnt_q != SW'(STABLE)) begin
         stab_cnt_d = stab_cnt_q + SW'(1);
      end
      stable = (stab_cnt_d == SW'(STABLE));
   end

   always_comb begin
      changed_d = 1'b0;
      for (int g = 0; g < GRIDS; g++) begin
         row_d[g]  = row_q[g];
         dcnt_d[g] = dcnt_q[g];
         lit_d[g]  = lit_q[g];
         if (stable && grid_q[g]) begin
            row_d[g]  = plate_q;
            dcnt_d[g] = DW'(DECAY);
            lit_d[g]  = 1'b1;
         end else if (dcnt_q[g] != '0) begin
            dcnt_d[g] = dcnt_q[g] - DW'(1);
            if (dcnt_q[g] == DW'(1)) begin
               row_d[g] = '0;
               lit_d[g] = 1'b0;
            end
         end
         if (row_d[g] != row_q[g]) begin
            changed_d = 1'b1;
         end
      end
   end

   always_comb begin
      rd_data_d = '0;
      for (int g = 0; g < GRIDS; g++) begin
         if (rd_addr == AW'(g)) begin
            rd_data_d = row_q[g];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grid_q     <= '0;
         plate_q    <= '0;
         stab_cnt_q <= '0;
         lit_q      <= '0;
         changed_q  <= 1'b0;
         rd_data_q  <= '0;
         for (int g = 0; g < GRIDS; g++) begin
            row_q[g]  <= '0;
            dcnt_q[g] <= '0;
         end
      end else begin
         grid_q     <= grid;
         plate_q    <= plate;
         stab_cnt_q <= stab_cnt_d;
         lit_q      <= lit_d;
         changed_q  <= changed_d;
         rd_data_q  <= rd_data_d;
         for (int g = 0; g < GRIDS; g++) begin
            row_q[g]  <= row_d[g];
            dcnt_q[g] <= dcnt_d[g];
         end
      end
   end

   assign rd_data = rd_data_q;
   assign row_lit = lit_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_vfd_grid_capture.sv
// Bench for vfd_grid_capture: directed scenarios plus random traffic against a timestamp-based model.
module tb_vfd_grid_capture;
   localparam int GRIDS  = 4;
   localparam int PLATES = 8;
   localparam int STABLE = 3;
   localparam int DECAY  = 10;
   localparam int AW     = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [GRIDS-1:0]  grid;
   logic [PLATES-1:0] plate;
   logic [AW-1:0]     rd_addr;
   logic [PLATES-1:0] rd_data;
   logic [GRIDS-1:0]  row_lit;
   logic              changed;

   vfd_grid_capture #(
      .GRIDS(GRIDS), .PLATES(PLATES), .STABLE(STABLE), .DECAY(DECAY), .AW(AW)
   ) dut (
      .clk(clk), .reset(reset), .grid(grid), .plate(plate),
      .rd_addr(rd_addr), .rd_data(rd_data), .row_lit(row_lit), .changed(changed)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: a row shows its last captured plate while fewer than DECAY edges have passed since capture.
   logic [GRIDS+PLATES-1:0] hist[$];
   int                now;
   int                last_ref [GRIDS];
   bit                has_ref  [GRIDS];
   logic [PLATES-1:0] stored   [GRIDS];
   logic [PLATES-1:0] vis      [GRIDS];
   logic [PLATES-1:0] prev_vis [GRIDS];
   logic [PLATES-1:0] exp_rd;
   logic [GRIDS-1:0]  exp_lit;
   logic              exp_changed;

   task automatic model_reset();
      hist.delete();
      hist.push_back('0);
      now = 0;
      for (int g = 0; g < GRIDS; g++) begin
         last_ref[g] = 0; has_ref[g] = 0; stored[g] = '0; vis[g] = '0; prev_vis[g] = '0;
      end
      exp_rd = '0; exp_lit = '0; exp_changed = 1'b0;
   endtask

   task automatic step();
      logic [GRIDS+PLATES-1:0] cur;
      bit st;
      @(posedge clk);
      cur = {grid, plate};
      now++;
      hist.push_back(cur);
      if (hist.size() > STABLE + 1) void'(hist.pop_front());
      st = (hist.size() == STABLE + 1);
      foreach (hist[i]) if (hist[i] != cur) st = 0;
      prev_vis = vis;
      exp_changed = 1'b0;
      for (int g = 0; g < GRIDS; g++) begin
         if (st && grid[g]) begin
            stored[g] = plate; last_ref[g] = now; has_ref[g] = 1;
         end
         exp_lit[g] = has_ref[g] && (now - last_ref[g]) < DECAY;
         vis[g] = exp_lit[g] ? stored[g] : '0;
         if (vis[g] != prev_vis[g]) exp_changed = 1'b1;
      end
      exp_rd = (int'(rd_addr) < GRIDS) ? prev_vis[rd_addr] : '0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; grid = '0; plate = '0; rd_addr = '0;
      repeat (3) @(posedge clk);
      model_reset();
      #1;
      total++;
      if ({rd_data, row_lit, changed} !== '0) begin
         bad++; $display("FAIL reset_init: got rd=%h lit=%b chg=%b want all 0", rd_data, row_lit, changed);
      end
      reset = 1'b0;
      grid = 4'b0010; plate = 8'hA5; rd_addr = 3'd1;
      repeat (6) step();
      total++;
      if (rd_data !== 8'hA5 || row_lit !== 4'b0010) begin
         bad++; $display("FAIL reset_preload: got rd=%h lit=%b want a5 0010", rd_data, row_lit);
      end
      reset = 1'b1; grid = '0; plate = '0;
      #1;
      total++;
      if ({rd_data, row_lit, changed} !== '0) begin
         bad++; $display("FAIL reset_async: got rd=%h lit=%b chg=%b want all 0", rd_data, row_lit, changed);
      end
      #2 reset = 1'b0;
      model_reset();
      repeat (2) step();
      total++;
      if (rd_data !== 8'h00 || {rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed}) begin
         bad++; $display("FAIL reset_after: got rd=%h lit=%b chg=%b want rd=00", rd_data, row_lit, changed);
      end
   endtask

   task automatic test_stable_capture();
      int pulses = 0;
      grid = 4'b0010; plate = 8'h3C; rd_addr = 3'd1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (changed) pulses++;
         total++;
         if ({rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed}) begin
            bad++; $display("FAIL capture_model step %0d: got rd=%h lit=%b chg=%b want rd=%h lit=%b chg=%b",
                            i, rd_data, row_lit, changed, exp_rd, exp_lit, exp_changed);
         end
         if (i == 3 || i == 4 || i == 5) begin
            total++;
            if ((i == 3 && row_lit !== 4'b0000) || (i == 4 && (row_lit !== 4'b0010 || rd_data !== 8'h00)) ||
                (i == 5 && rd_data !== 8'h3C)) begin
               bad++; $display("FAIL capture_latency step %0d: got rd=%h lit=%b", i, rd_data, row_lit);
            end
         end
      end
      total++;
      if (pulses !== 1) begin
         bad++; $display("FAIL capture_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_decay();
      int pulses = 0;
      grid = 4'b0000;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (changed) pulses++;
         total++;
         if ({rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed}) begin
            bad++; $display("FAIL decay_model step %0d: got rd=%h lit=%b chg=%b want rd=%h lit=%b chg=%b",
                            i, rd_data, row_lit, changed, exp_rd, exp_lit, exp_changed);
         end
         if (i == 9 || i == 10 || i == 11) begin
            total++;
            if ((i == 9 && row_lit[1] !== 1'b1) || (i == 10 && (row_lit[1] !== 1'b0 || rd_data !== 8'h3C)) ||
                (i == 11 && rd_data !== 8'h00)) begin
               bad++; $display("FAIL decay_timing step %0d: got rd=%h lit=%b", i, rd_data, row_lit);
            end
         end
      end
      total++;
      if (pulses !== 1) begin
         bad++; $display("FAIL decay_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_glitch();
      grid = 4'b0001; plate = 8'hFF; rd_addr = 3'd0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 3) plate = 8'h0F;
         step();
         total++;
         if (rd_data === 8'hFF || {rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed}) begin
            bad++; $display("FAIL glitch step %0d: got rd=%h lit=%b chg=%b want rd=%h lit=%b chg=%b",
                            i, rd_data, row_lit, changed, exp_rd, exp_lit, exp_changed);
         end
      end
      total++;
      if (rd_data !== 8'h0F) begin
         bad++; $display("FAIL glitch_final: got %h want 0f", rd_data);
      end
   endtask

   task automatic test_multi_grid();
      int pulses = 0;
      grid = 4'b1001; plate = 8'h81;
      for (int i = 1; i <= 50; i++) begin
         rd_addr = i[0] ? 3'd0 : 3'd3;
         step();
         if (changed) pulses++;
         total++;
         if ({rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed} ||
             (i >= 4 && row_lit !== 4'b1001) || (i >= 6 && rd_data !== 8'h81)) begin
            bad++; $display("FAIL multi step %0d: got rd=%h lit=%b chg=%b want rd=%h lit=%b chg=%b",
                            i, rd_data, row_lit, changed, exp_rd, exp_lit, exp_changed);
         end
      end
      total++;
      if (pulses !== 1) begin
         bad++; $display("FAIL multi_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_rdw_oor();
      grid = 4'b0100; plate = 8'h5A; rd_addr = 3'd2;
      repeat (6) step();
      plate = 8'hC3;
      for (int i = 1; i <= 6; i++) begin
         step();
         total++;
         if ({rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed} ||
             (i == 4 && rd_data !== 8'h5A) || (i == 5 && rd_data !== 8'hC3)) begin
            bad++; $display("FAIL rdw step %0d: got rd=%h lit=%b chg=%b want rd=%h", i, rd_data, row_lit, changed, exp_rd);
         end
      end
      rd_addr = 3'd7;
      step();
      total++;
      if (rd_data !== 8'h00) begin
         bad++; $display("FAIL oor_7: got %h want 00", rd_data);
      end
      rd_addr = 3'd5;
      step();
      total++;
      if (rd_data !== 8'h00) begin
         bad++; $display("FAIL oor_5: got %h want 00", rd_data);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      for (int i = 0; i < 400; i++) begin
         if (hold == 0) begin
            hold = $urandom_range(1, 7);
            if ($urandom_range(0, 3) != 0) grid = 4'($urandom_range(0, 15));
            plate = 8'($urandom_range(0, 255));
         end
         hold--;
         rd_addr = 3'($urandom_range(0, 7));
         step();
         total++;
         if ({rd_data, row_lit, changed} !== {exp_rd, exp_lit, exp_changed}) begin
            bad++; $display("FAIL random step %0d: got rd=%h lit=%b chg=%b want rd=%h lit=%b chg=%b",
                            i, rd_data, row_lit, changed, exp_rd, exp_lit, exp_changed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stable_capture();
      test_decay();
      test_glitch();
      test_multi_grid();
      test_rdw_oor();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
